// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states and
// datapath select values, also consumed by the datapath and ALU control.
package mc_pkg;

    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_R    = 4'b0000;
    localparam logic [OPW-1:0] OP_ADDI = 4'b0001;
    localparam logic [OPW-1:0] OP_LW   = 4'b0010;
    localparam logic [OPW-1:0] OP_SW   = 4'b0011;
    localparam logic [OPW-1:0] OP_BEQ  = 4'b0100;
    localparam logic [OPW-1:0] OP_BNE  = 4'b0101;
    localparam logic [OPW-1:0] OP_J    = 4'b0110;
    localparam logic [OPW-1:0] OP_HALT = 4'b1111;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_ALU_WB_R = 4'd4,
        S_EXEC_I   = 4'd5,
        S_ALU_WB_I = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] FETCH_PC_INC = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;

    function automatic logic op_is_legal(input logic [OPW-1:0] op);
        return (op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT});
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the control FSM (master) and the multicycle datapath.
interface mc_control_fsm_if;

    logic [mc_pkg::OPW-1:0] opcode;
    logic                   mem_ready;
    logic                   pc_write;
    logic                   pc_write_cond;
    logic                   branch_ne;
    logic [1:0]             pc_src;
    logic                   iord;
    logic                   mem_read;
    logic                   mem_write;
    logic                   ir_write;
    logic                   reg_dst;
    logic                   mem_to_reg;
    logic                   reg_write;
    logic                   alu_src_a;
    logic [1:0]             alu_src_b;
    logic [1:0]             alu_op;
    logic                   halted;
    logic                   illegal_op;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_ne, pc_src, iord, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, halted, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, pc_src, iord, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, halted, illegal_op
    );

endinterface

// File: rtl/mc_control_fsm.sv
// Moore control FSM for the multicycle processor; outputs decode from state,
// with only the FETCH IR/PC loads qualified by the memory handshake.
//
// state    | meaning
// RESET    | post-reset idle, all outputs low
// FETCH    | read instruction at PC, PC+1 on mem_ready
// DECODE   | compute branch target into ALUOut, dispatch on opcode
// EXEC_R   | A op B (funct-decoded)
// ALU_WB_R | write ALUOut to rd
// EXEC_I   | A + imm
// ALU_WB_I | write ALUOut to rt
// MEM_ADDR | A + imm effective address
// MEM_RD   | load, wait for mem_ready
// MEM_WB   | write MDR to rt
// MEM_WR   | store, wait for mem_ready
// BRANCH   | A - B, conditional PC load from ALUOut
// JUMP     | PC <= jump target
// HALT     | parked until reset
module mc_control_fsm
    import mc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    mc_control_fsm_if.master ctl
);

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:    state_d = S_FETCH;
            S_FETCH:    if (ctl.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (ctl.opcode)
                    OP_R:         state_d = S_EXEC_R;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_HALT:      state_d = S_HALT;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_EXEC_R:   state_d = S_ALU_WB_R;
            S_ALU_WB_R: state_d = S_FETCH;
            S_EXEC_I:   state_d = S_ALU_WB_I;
            S_ALU_WB_I: state_d = S_FETCH;
            S_MEM_ADDR: state_d = (ctl.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (ctl.mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (ctl.mem_ready) state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctl.pc_write      = 1'b0;
        ctl.pc_write_cond = 1'b0;
        ctl.branch_ne     = 1'b0;
        ctl.pc_src        = PC_SRC_ALU;
        ctl.iord          = 1'b0;
        ctl.mem_read      = 1'b0;
        ctl.mem_write     = 1'b0;
        ctl.ir_write      = 1'b0;
        ctl.reg_dst       = 1'b0;
        ctl.mem_to_reg    = 1'b0;
        ctl.reg_write     = 1'b0;
        ctl.alu_src_a     = 1'b0;
        ctl.alu_src_b     = SRC_B_REG;
        ctl.alu_op        = ALU_OP_ADD;
        ctl.halted        = 1'b0;
        ctl.illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = FETCH_PC_INC;
                ctl.ir_write  = ctl.mem_ready;
                ctl.pc_write  = ctl.mem_ready;
            end
            S_DECODE: begin
                ctl.alu_src_b  = SRC_B_IMM;
                ctl.illegal_op = !op_is_legal(ctl.opcode);
            end
            S_EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALU_OP_FUNCT;
            end
            S_ALU_WB_R: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRC_B_IMM;
            end
            S_ALU_WB_I: ctl.reg_write = 1'b1;
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = ALU_OP_SUB;
                ctl.pc_src        = PC_SRC_ALUOUT;
                ctl.pc_write_cond = 1'b1;
                ctl.branch_ne     = (ctl.opcode == OP_BNE);
            end
            S_JUMP: begin
                ctl.pc_write = 1'b1;
                ctl.pc_src   = PC_SRC_JUMP;
            end
            S_HALT:  ctl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control unit for the multicycle processor.
- A Moore-style state machine that sequences the shared datapath (PC, IR, register file, ALU, memory) through fetch, decode, execute, memory and writeback steps.
- Drives every datapath enable and mux select, including pc_write_cond, the enable for the gated branch AND that qualifies ALU zero.
- Waits on a memory-ready handshake.

Parameters:
- OPW, 4, opcode field width (instr[15:12])
- FETCH_PC_INC, 2'b01, alu_src_b select for the +1 PC increment constant

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  4  IR[15:12], valid from DECODE onward
- mem_ready  in  1  memory handshake; 1 = read data valid / write accepted this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  enable for the gated branch AND
- branch_ne  out  1  1 = branch on not-zero (BNE), 0 = on zero (BEQ)
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- iord  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 MDR
- reg_write  out  1  register file write
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  00 B, 01 const 1, 10 sign-ext imm
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- halted  out  1  high while in HALT
- illegal_op  out  1  one-cycle pulse on unknown opcode

Behaviour:
- rst_n low: state forced to RESET immediately, asynchronously. All outputs are 0 in RESET.
- RESET -> FETCH on the first clk edge after rst_n deasserts.
- Reset asserted mid-operation aborts the current instruction. No memory request survives reset.
- Outputs decode from the state register, except ir_write and pc_write in FETCH, which are additionally qualified by mem_ready.
- Unlisted outputs are 0 in every state.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write = pc_write = mem_ready.
  - Stay in FETCH while mem_ready=0. mem_ready=1 -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0000 R -> EXEC_R
  - 0001 ADDI -> EXEC_I
  - 0010 LW or 0011 SW -> MEM_ADDR
  - 0100 BEQ or 0101 BNE -> BRANCH
  - 0110 J -> JUMP
  - 1111 HALT -> HALT
  - any other opcode: illegal_op=1 for this cycle, -> FETCH
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB_R.
- ALU_WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 -> ALU_WB_I.
- ALU_WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready=1, then -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready=1, then -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write_cond=1, branch_ne = (opcode==0101) -> FETCH.
- JUMP: pc_write=1, pc_src=10 -> FETCH.
- HALT: halted=1. Remains in HALT until rst_n. opcode and mem_ready are ignored.
- Memory request signals (mem_read/mem_write, iord) are held stable for the whole wait period.
- Cycle counts with mem_ready tied high:
  - R / ADDI / BEQ / BNE / J: 4, 4, 3, 3, 3
  - LW: 5
  - SW: 4
- Each memory wait cycle adds 1.
- Undefined state encodings recover to FETCH (default branch).

Decomposition:
- Package mc_pkg holds:
  - opcode localparams (OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT)
  - 4-bit state encodings
  - alu_op / pc_src / alu_src_b select constants
- Shared with the datapath and ALU control.
- No sub-module: the next-state logic and output decode live in one module as two always blocks.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> all outputs 0 in the same delta. Release -> FETCH with mem_read=1 on the next cycle.
- R-type, mem_ready=1, opcode=0000 -> FETCH, DECODE, EXEC_R, ALU_WB_R. reg_write=1 and reg_dst=1 only in cycle 4. Back in FETCH at cycle 5.
- LW with mem_ready low 3 cycles in MEM_RD:
  - mem_read=1 and iord=1 held for 4 cycles, reg_write not yet asserted.
  - MEM_WB asserts mem_to_reg=1 and reg_write=1.
  - Total 8 cycles.
- BNE, opcode=0101 -> in cycle 3, pc_write_cond=1, branch_ne=1, pc_src=01, alu_op=01. pc_write=0 throughout that cycle.
- FETCH stall: mem_ready=0 for 2 cycles -> ir_write=0 and pc_write=0 during the stall. Both pulse exactly once, when mem_ready=1.
- Illegal opcode 1010 -> illegal_op pulses for 1 cycle in DECODE, then FETCH. HALT opcode 1111 -> halted stays 1 indefinitely and clears only on rst_n.
